coef_bank_seq: RTL and testbench
================================

Name: coef_bank_seq

Overview:
- Parametrised successor to the fixed 5 kHz low-pass coefficient table.
- Holds NUM_FILT biquad coefficient sets, each with 6 coefficients (a0, a1, a2, b0, b1, b2), in double-buffered registers (shadow plus active).
- On a start strobe, streams the active set for the selected filter to the IIR datapath, one coefficient per clock.
- Coefficients are runtime-writable; new values take effect only at a frame boundary.

Parameters:
- CANT_BITS, 25, coefficient width in bits. Must be ≥ 25; reset constants are sign-extended from 25 bits.
- NUM_FILT, 4, number of coefficient sets. Range 1..16.
- FILT_W, 2, width of filter index; equals clog2(NUM_FILT), minimum 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a coefficient frame.
- filt_sel  in  FILT_W  filter set to stream; sampled only on an accepted start.
- wr_en  in  1  write strobe into the shadow bank.
- wr_filt  in  FILT_W  shadow set index to write.
- wr_idx  in  3  coefficient index: 0=a0, 1=a1, 2=a2, 3=b0, 4=b1, 5=b2.
- wr_data  in  CANT_BITS  coefficient value, two's complement.
- commit  in  1  one-cycle pulse; request to copy the entire shadow bank into the active bank.
- cte  out  CANT_BITS  current coefficient.
- sel_cte  out  4  datapath code for cte: a0=0000, a1=0001, a2=0010, b0=0101, b1=0110, b2=0111.
- cte_valid  out  1  cte and sel_cte are valid this cycle.
- cte_last  out  1  high together with the b2 beat.
- busy  out  1  a frame is in progress.
- commit_pend  out  1  a commit is accepted but not yet applied.

Behaviour:
- Reset (synchronous, dominant over all inputs):
  - Outputs: cte=0, sel_cte=0000, cte_valid=0, cte_last=0, busy=0, commit_pend=0.
  - Sequencer returns to IDLE.
  - Set 0 (active and shadow) = {a0=25'h4000, a1=25'h423D, a2=25'h1FFE876, b0=25'h552, b1=25'hAA5, b2=25'h552}, sign-extended to CANT_BITS.
  - All other sets = 0.
  - Reset during a frame aborts it; no further beats are emitted.
- Sequencer FSM, states IDLE, RUN:
  - IDLE: start=1 latches filt_sel, clears the 3-bit beat counter k, and moves to RUN.
  - RUN: each cycle registers cte=active[filt][k], sel_cte=code(k), cte_valid=1; then k increments.
  - In RUN with k=5: cte_last=1, next state IDLE.
  - Latency: start accepted at cycle t gives cte_valid in cycles t+1..t+6 and cte_last at t+6. busy is high t+1..t+6.
  - Back-to-back: a start in cycle t+6 is accepted and its first beat appears at t+7, so there are no gaps. All other starts while busy are ignored (not queued).
  - filt_sel ≥ NUM_FILT: the frame still runs and emits zeros on cte with normal sel_cte, valid and last.
  - Outside RUN: cte_valid=0 and cte_last=0. cte and sel_cte hold their last value.
- Writes:
  - wr_en writes shadow[wr_filt][wr_idx] in one cycle.
  - Writes are ignored if wr_idx > 5 or wr_filt ≥ NUM_FILT.
  - Writes never alter active, even mid-frame.
- Commit:
  - commit sets commit_pend.
  - The active ← shadow copy (all sets) happens in the first cycle in which commit_pend=1 and the sequencer is in IDLE, or is finishing a frame (k=5 beat); commit_pend clears in that same cycle.
  - A frame in progress therefore always uses a single consistent set.
  - commit plus start in the same IDLE cycle: the commit applies first, so the frame streams the new values. The copy happens on that edge and the first beat is read the following cycle.
  - commit while commit_pend=1: merged; a single copy occurs.
  - wr_en plus a commit copy in the same cycle: the copy uses the pre-write shadow. The write lands in shadow only.

Test Plan:
- Reset, then start with filt_sel=0 → beats t+1..t+6: cte=4000, 423D, 1FFE876, 552, AA5, 552 (25-bit); sel_cte=0,1,2,5,6,7; cte_last only on the 6th beat.
- Write shadow set 1 = {1,2,3,4,5,6}, then start filt_sel=1 with no commit → six zero beats. Then commit, start filt_sel=1 → beats 1..6.
- During a frame on set 1, write shadow[1][3]=7FF and pulse commit at beat 2 → current frame still shows b0=4 and commit_pend stays high until the last beat. The next frame shows b0=7FF.
- start at t and t+6, plus an extra start at t+3 → 12 contiguous valid beats; the t+3 start is ignored; busy never drops between frames.
- Assert reset at beat 3 → cte_valid=0, busy=0 next cycle; set 1 active reads all zeros; set 0 restored to the defaults.
- wr_idx=6 and wr_filt=NUM_FILT writes, followed by commit and a start on every set → no coefficient changes.

Source files
------------

// File: rtl/coef_bank_seq.sv
// Double-buffered biquad coefficient bank with a frame sequencer that streams
// the six coefficients of one filter set to the IIR datapath, one per clock.
module coef_bank_seq #(
    parameter int CANT_BITS = 25,
    parameter int NUM_FILT  = 4,
    parameter int FILT_W    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [FILT_W-1:0]    filt_sel,
    input  logic                 wr_en,
    input  logic [FILT_W-1:0]    wr_filt,
    input  logic [2:0]           wr_idx,
    input  logic [CANT_BITS-1:0] wr_data,
    input  logic                 commit,
    output logic [CANT_BITS-1:0] cte,
    output logic [3:0]           sel_cte,
    output logic                 cte_valid,
    output logic                 cte_last,
    output logic                 busy,
    output logic                 commit_pend
);
    typedef logic [NUM_FILT-1:0][5:0][CANT_BITS-1:0] bank_t;
    typedef enum logic {IDLE, RUN} state_t;

    state_t            state;
    logic [2:0]        k;
    logic [FILT_W-1:0] filt;
    bank_t             shadow, active;

    logic                 last_beat, take, do_copy;
    logic [FILT_W-1:0]    nf;
    logic [2:0]           nk;
    logic [3:0]           ncode;
    logic [CANT_BITS-1:0] nval;
    bank_t                src;

    // Set 0 powers up as the legacy 5 kHz low-pass; constants are 25-bit signed.
    function automatic logic [CANT_BITS-1:0] rst_coef(input int f, input int i);
        logic signed [24:0] v;
        v = '0;
        if (f == 0) begin
            case (i)
                0:       v = 25'h0004000;
                1:       v = 25'h000423D;
                2:       v = 25'h1FFE876;
                3:       v = 25'h0000552;
                4:       v = 25'h0000AA5;
                default: v = 25'h0000552;
            endcase
        end
        return CANT_BITS'(v);
    endfunction

    always_comb begin
        last_beat = (state == RUN) && (k == 3'd5);
        take      = start && ((state == IDLE) || last_beat);
        do_copy   = (commit_pend || commit) && ((state == IDLE) || last_beat);
        nf        = take ? filt_sel : filt;
        nk        = take ? 3'd0 : k + 3'd1;
        ncode     = (nk < 3'd3) ? {1'b0, nk} : {1'b0, nk} + 4'd2;
        // A copy on this edge must already be visible to the beat being loaded.
        src       = do_copy ? shadow : active;
        nval      = '0;
        if ((int'(nf) < NUM_FILT) && (nk <= 3'd5))
            nval = src[nf][nk];
    end

    assign busy = (state == RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            k         <= '0;
            filt      <= '0;
            cte       <= '0;
            sel_cte   <= '0;
            cte_valid <= 1'b0;
            cte_last  <= 1'b0;
        end else if (take || ((state == RUN) && !last_beat)) begin
            state     <= RUN;
            k         <= nk;
            filt      <= nf;
            cte       <= nval;
            sel_cte   <= ncode;
            cte_valid <= 1'b1;
            cte_last  <= (nk == 3'd5);
        end else begin
            state     <= IDLE;
            cte_valid <= 1'b0;
            cte_last  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int f = 0; f < NUM_FILT; f++) begin
                for (int i = 0; i < 6; i++) begin
                    shadow[f][i] <= rst_coef(f, i);
                    active[f][i] <= rst_coef(f, i);
                end
            end
            commit_pend <= 1'b0;
        end else begin
            if (do_copy) begin
                active      <= shadow;
                commit_pend <= 1'b0;
            end else if (commit) begin
                commit_pend <= 1'b1;
            end
            if (wr_en && (wr_idx <= 3'd5) && (int'(wr_filt) < NUM_FILT))
                shadow[wr_filt][wr_idx] <= wr_data;
        end
    end
endmodule

// File: tb/tb_coef_bank_seq.sv
// Scoreboard bench for coef_bank_seq: a frame-level model queues expected beats,
// a negedge monitor pops and compares them against the streamed outputs.
module tb_coef_bank_seq;
    localparam int CB = 27;
    localparam int NF = 3;
    localparam int FW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0, wr_en = 1'b0, commit = 1'b0;
    logic [FW-1:0] filt_sel = '0, wr_filt = '0;
    logic [2:0]    wr_idx = '0;
    logic [CB-1:0] wr_data = '0;
    logic [CB-1:0] cte;
    logic [3:0]    sel_cte;
    logic          cte_valid, cte_last, busy, commit_pend;

    coef_bank_seq #(.CANT_BITS(CB), .NUM_FILT(NF), .FILT_W(FW)) dut (
        .clk(clk), .reset(reset), .start(start), .filt_sel(filt_sel),
        .wr_en(wr_en), .wr_filt(wr_filt), .wr_idx(wr_idx), .wr_data(wr_data),
        .commit(commit), .cte(cte), .sel_cte(sel_cte), .cte_valid(cte_valid),
        .cte_last(cte_last), .busy(busy), .commit_pend(commit_pend)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CB-1:0] c;
        logic [3:0]    s;
        logic          l;
    } beat_t;

    beat_t         q[$];
    logic [CB-1:0] msh[NF][6];
    logic [CB-1:0] mac[NF][6];
    logic          mpend = 1'b0;
    int            rem = 0;
    int            npass = 0, ntot = 0;
    logic          mon_en = 1'b0;
    bit            acc, cp;
    int            codes[6] = '{0, 1, 2, 5, 6, 7};
    int            defs[6]  = '{16384, 16957, -6026, 1362, 2725, 1362};

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else npass++;
    endtask

    task automatic model_reset();
        for (int f = 0; f < NF; f++)
            for (int i = 0; i < 6; i++) begin
                msh[f][i] = (f == 0) ? CB'(defs[i]) : '0;
                mac[f][i] = msh[f][i];
            end
        mpend = 1'b0;
        rem = 0;
        q.delete();
    endtask

    initial model_reset();

    // Frame-level reference: a start is taken when no beats are owed beyond the current one.
    always @(posedge clk) begin
        if (reset) begin
            model_reset();
        end else begin
            acc = start && (rem <= 1);
            cp  = (mpend || commit) && (rem <= 1);
            if (cp) begin
                mac   = msh;
                mpend = 1'b0;
            end else if (commit) begin
                mpend = 1'b1;
            end
            if (acc) begin
                for (int i = 0; i < 6; i++) begin
                    beat_t b;
                    b.c = (int'(filt_sel) < NF) ? mac[filt_sel][i] : '0;
                    b.s = 4'(codes[i]);
                    b.l = (i == 5);
                    q.push_back(b);
                end
                rem = 6;
            end else if (rem > 0) begin
                rem = rem - 1;
            end
            if (wr_en && wr_idx <= 3'd5 && int'(wr_filt) < NF)
                msh[wr_filt][wr_idx] = wr_data;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("busy", 64'(busy), 64'(rem > 0));
            check("commit_pend", 64'(commit_pend), 64'(mpend));
            check("cte_valid", 64'(cte_valid), 64'(rem > 0));
            if (cte_valid && rem > 0) begin
                if (q.size() == 0) begin
                    ntot++;
                    $display("FAIL scoreboard: beat seen, got none expected");
                end else begin
                    beat_t e;
                    e = q.pop_front();
                    check("cte", 64'(cte), 64'(e.c));
                    check("sel_cte", 64'(sel_cte), 64'(e.s));
                    check("cte_last", 64'(cte_last), 64'(e.l));
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            start = 1'b0; commit = 1'b0; wr_en = 1'b0;
        end
    endtask

    task automatic do_start(input int f);
        start = 1'b1; filt_sel = FW'(f);
        cyc(1);
    endtask

    task automatic do_write(input int f, input int i, input int d);
        wr_en = 1'b1; wr_filt = FW'(f); wr_idx = 3'(i); wr_data = CB'(d);
        cyc(1);
    endtask

    task automatic do_commit();
        commit = 1'b1;
        cyc(1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        check("rst_cte", 64'(cte), 64'd0);
        check("rst_sel", 64'(sel_cte), 64'd0);
        check("rst_last", 64'(cte_last), 64'd0);
        reset = 1'b0;
        cyc(1);

        // default set 0
        do_start(0); cyc(7);

        // shadow writes invisible until commit
        for (int i = 0; i < 6; i++) do_write(1, i, i + 1);
        do_start(1); cyc(7);
        do_commit(); cyc(1);
        do_start(1); cyc(7);

        // write + commit mid-frame: frame stays consistent, next frame sees it
        do_start(1); cyc(1);
        wr_en = 1'b1; wr_filt = 2'd1; wr_idx = 3'd3; wr_data = CB'(32'h7FF); commit = 1'b1;
        cyc(1); cyc(6);
        do_start(1); cyc(7);

        // back-to-back with an ignored start in the middle
        do_start(0); cyc(2); do_start(2); cyc(2); do_start(1); cyc(8);

        // commit and start together: new values stream immediately
        do_write(2, 0, 32'h1234);
        commit = 1'b1; start = 1'b1; filt_sel = 2'd2; cyc(1); cyc(7);

        // reset mid-frame
        do_start(1); cyc(2);
        reset = 1'b1; cyc(1); reset = 1'b0;
        do_start(1); cyc(7);
        do_start(0); cyc(7);

        // out-of-range writes and an out-of-range filter select
        do_write(0, 6, 32'h155);
        do_write(3, 0, 32'h2AA);
        do_commit(); cyc(1);
        for (int f = 0; f < 4; f++) begin do_start(f); cyc(7); end

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            start    = ($urandom % 4) == 0;
            filt_sel = FW'($urandom % 4);
            wr_en    = ($urandom % 3) == 0;
            wr_filt  = FW'($urandom % 4);
            wr_idx   = 3'($urandom % 8);
            wr_data  = CB'($urandom);
            commit   = ($urandom % 8) == 0;
            reset    = ($urandom % 250) == 0;
            @(negedge clk);
        end
        reset = 1'b0;
        cyc(10);
        check("q_drain", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
